simmem_wresp_bank: RTL and testbench
====================================

# simmem_wresp_bank

Write response bank of the simulated memory controller, directly downstream of the delay calculator. It reserves one slot per accepted write address and hands the slot index back as the internal identifier. It stores write responses returned by the real memory and releases each response to the requester only once the delay calculator has raised that slot's release enable. On each release it pulses the slot's released-address bit back to the delay calculator.

## Interface
- `Capacity`, 8: number of response slots; power of two, ≥2; equals `simmem_pkg::WriteRespBankCapacity` at instantiation.
- `IdWidth`, 4: AXI write ID width.
- `RespWidth`, 2: BRESP payload width.
- `IidWidth`, `$clog2(Capacity)`: internal identifier width; derived, not overridden.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `res_valid_i` in 1: write address accepted upstream; reserve a slot.
- `res_id_i` in IdWidth: AXI ID of the reserving write.
- `res_ready_o` out 1: a free slot exists.
- `res_iid_o` out IidWidth: index of the slot to be reserved; fed to the delay calculator `waddr_iid_i`.
- `rsp_valid_i` in 1: write response from real memory.
- `rsp_id_i` in IdWidth: response ID.
- `rsp_data_i` in RespWidth: response payload.
- `rsp_ready_o` out 1: a RESERVED slot with a matching ID exists.
- `release_en_onehot_i` in Capacity: release enables from the delay calculator.
- `released_addr_onehot_o` out Capacity: one-hot pulse of the slot released this cycle.
- `out_valid_o` out 1: releasable response present.
- `out_id_o` out IdWidth, `out_data_o` out RespWidth: released response.
- `out_ready_i` in 1: requester accepts the response.

## Operation
- Each slot has state FREE, RESERVED or FILLED. Each slot stores `id`, `data`, and a row of a Capacity×Capacity age matrix; bit [i][j]=1 means slot i was reserved before slot j.
- Reservation:
  - `res_ready_o` = any slot FREE.
  - `res_iid_o` = the lowest-index FREE slot.
  - On `res_valid_i && res_ready_o`: FREE→RESERVED and `id` is stored. The slot's row is set to all zeros; its column is set to ones for every occupied slot.
- Response fill:
  - The target is the oldest RESERVED slot whose `id == rsp_id_i`.
  - `rsp_ready_o` depends combinationally on `rsp_id_i`.
  - On handshake: RESERVED→FILLED and `data` is stored.
  - If no slot matches, `rsp_ready_o`=0 and the response stalls.
- Release eligibility: a slot is eligible when it is FILLED, its `release_en_onehot_i` bit is 1, and no older occupied slot has the same `id` (per-ID AXI ordering).
  - `out_*` presents the oldest eligible slot.
  - `out_valid_o` = any slot eligible.
- Release: on `out_valid_o && out_ready_i`, the slot goes FILLED→FREE. Its bit in `released_addr_onehot_o` is 1 in that same cycle and 0 otherwise, so the output is 0 or one-hot.
- The age matrix is maintained only for occupied slots. Bits of FREE slots are don't-care but must not affect selection.

## Timing
- Reset values:
  - All slots FREE.
  - `res_ready_o`=1, `res_iid_o`=0.
  - `rsp_ready_o`=0, `out_valid_o`=0.
  - `out_id_o`=0, `out_data_o`=0 (outputs are zero-masked when not valid).
  - `released_addr_onehot_o`=0.
- Every output is combinational from registered state plus same-cycle inputs. There is no added pipeline stage.
- Reservation to fill: a response can match a slot at the earliest one cycle after that slot's reservation handshake.
- Fill to release: a response becomes eligible at the earliest the cycle after the fill.
- A slot freed in cycle N is reservable from cycle N+1. `res_ready_o` is computed from the registered state only.
- Simultaneous reservation, fill and release in one cycle touch distinct slots and must all complete.
- Full bank: `res_ready_o`=0 and reservations back-pressure. Fill and release continue.
- If `out_ready_i`=0, the selection may change as enables or fills arrive, but `out_valid_o` never drops while any slot stays eligible.
- Reset asserted mid-operation returns all slots to FREE immediately. Stored responses are lost.

## Configuration
- `SIMMEM_WRESP_BANK_ASSERT_EN` defined: SVA checks are compiled in.
  - `released_addr_onehot_o` is `$onehot0`.
  - Released slot index equals the slot whose data drives `out_*`.
  - No release of a slot whose enable is 0.
  - `rsp_valid_i` with no matching reservation for 1000 consecutive cycles fires an error.
- Undefined: no assertions. Functional behaviour is identical.

## Test plan
- Reserve IDs 3,5 (iids 0,1); return responses 5/OKAY then 3/SLVERR; enable {1,1}. Required: first response out is ID 3 SLVERR (oldest eligible), then ID 5; `released_addr_onehot_o` = 8'b01 then 8'b10.
- Reserve ID 2 twice (iids 0,1); fill both; enable only bit 1. Required: `out_valid_o`=0. Then enable bit 0: slot 0 out, then slot 1.
- Fill all 8 slots. Required: `res_ready_o`=0. Release slot 4. Required: `res_ready_o`=1 next cycle and `res_iid_o`=4.
- Same cycle: reserve (iid 2), fill slot 1, release slot 0 with `out_ready_i`=1. Required: all three complete; next-cycle states FREE/FILLED/RESERVED.
- Response with ID 7 and no reservation. Required: `rsp_ready_o`=0. Reserve ID 7. Required: `rsp_ready_o`=1 next cycle and the fill is accepted.
- Assert `rst_ni` low with 3 slots FILLED. Required: immediately `out_valid_o`=0, `res_ready_o`=1, `res_iid_o`=0.

Source files
------------

// File: rtl/simmem_wresp_bank.sv
// simmem_wresp_bank: write response bank of the simulated memory controller.
// Reserves one slot per accepted write address and returns the slot index as
// the internal ID. Holds write responses until the delay calculator enables
// their release. Releases follow per-ID AXI ordering, oldest first.
// Optional macro SIMMEM_WRESP_BANK_ASSERT_EN compiles in SVA checks.
module simmem_wresp_bank #(
    parameter int  Capacity  = 8,
    parameter int  IdWidth   = 4,
    parameter int  RespWidth = 2,
    localparam int IidWidth  = $clog2(Capacity)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 res_valid_i,
    input  logic [IdWidth-1:0]   res_id_i,
    output logic                 res_ready_o,
    output logic [IidWidth-1:0]  res_iid_o,
    input  logic                 rsp_valid_i,
    input  logic [IdWidth-1:0]   rsp_id_i,
    input  logic [RespWidth-1:0] rsp_data_i,
    output logic                 rsp_ready_o,
    input  logic [Capacity-1:0]  release_en_onehot_i,
    output logic [Capacity-1:0]  released_addr_onehot_o,
    output logic                 out_valid_o,
    output logic [IdWidth-1:0]   out_id_o,
    output logic [RespWidth-1:0] out_data_o,
    input  logic                 out_ready_i
);

    typedef enum logic [1:0] {
        SlotFree     = 2'd0,
        SlotReserved = 2'd1,
        SlotFilled   = 2'd2
    } slot_state_e;

    slot_state_e          state_q [Capacity];
    slot_state_e          state_d [Capacity];
    logic [IdWidth-1:0]   id_q    [Capacity];
    logic [IdWidth-1:0]   id_d    [Capacity];
    logic [RespWidth-1:0] data_q  [Capacity];
    logic [RespWidth-1:0] data_d  [Capacity];
    // age_q[i][j] = 1: slot i was reserved before slot j (valid for occupied slots only)
    logic [Capacity-1:0]  age_q   [Capacity];
    logic [Capacity-1:0]  age_d   [Capacity];

    logic [Capacity-1:0] free_v, occ_v, match_v, elig_v;
    logic [Capacity-1:0] res_oh, fill_oh, out_oh;
    logic                res_fire, rsp_fire, out_fire;

    // Per-slot status vectors and same-ID eligibility filtering
    always_comb begin
        for (int i = 0; i < Capacity; i++) begin
            free_v[i]  = (state_q[i] == SlotFree);
            occ_v[i]   = (state_q[i] != SlotFree);
            match_v[i] = (state_q[i] == SlotReserved) && (id_q[i] == rsp_id_i);
            elig_v[i]  = (state_q[i] == SlotFilled) && release_en_onehot_i[i];
            for (int j = 0; j < Capacity; j++) begin
                if (j != i && occ_v[j] && id_q[j] == id_q[i] && age_q[j][i]) begin
                    elig_v[i] = 1'b0;
                end
            end
        end
    end

    // Selection: lowest free slot, oldest matching reservation, oldest eligible
    always_comb begin
        res_oh    = '0;
        res_iid_o = '0;
        for (int i = Capacity - 1; i >= 0; i--) begin
            if (free_v[i]) begin
                res_oh    = '0;
                res_oh[i] = 1'b1;
                res_iid_o = IidWidth'(i);
            end
        end
        // Only candidates take part, so stale age bits of free slots never matter
        fill_oh = match_v;
        out_oh  = elig_v;
        for (int i = 0; i < Capacity; i++) begin
            for (int j = 0; j < Capacity; j++) begin
                if (match_v[j] && age_q[j][i]) fill_oh[i] = 1'b0;
                if (elig_v[j] && age_q[j][i])  out_oh[i]  = 1'b0;
            end
        end
    end

    // Output mux, zero when nothing is releasable
    always_comb begin
        out_id_o   = '0;
        out_data_o = '0;
        for (int i = 0; i < Capacity; i++) begin
            if (out_oh[i]) begin
                out_id_o   = out_id_o | id_q[i];
                out_data_o = out_data_o | data_q[i];
            end
        end
    end

    assign res_ready_o            = |free_v;
    assign rsp_ready_o            = |match_v;
    assign out_valid_o            = |elig_v;
    assign res_fire               = res_valid_i && res_ready_o;
    assign rsp_fire               = rsp_valid_i && rsp_ready_o;
    assign out_fire               = out_valid_o && out_ready_i;
    assign released_addr_onehot_o = out_fire ? out_oh : '0;

    // Next state: reservation, fill and release always hit distinct slots
    always_comb begin
        for (int i = 0; i < Capacity; i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            data_d[i]  = data_q[i];
            age_d[i]   = age_q[i];
        end
        for (int i = 0; i < Capacity; i++) begin
            if (res_fire && res_oh[i]) begin
                state_d[i] = SlotReserved;
                id_d[i]    = res_id_i;
                age_d[i]   = '0;
            end
            if (rsp_fire && fill_oh[i]) begin
                state_d[i] = SlotFilled;
                data_d[i]  = rsp_data_i;
            end
            if (out_fire && out_oh[i]) begin
                state_d[i] = SlotFree;
            end
        end
        // New slot is younger than every currently occupied slot
        for (int i = 0; i < Capacity; i++) begin
            for (int j = 0; j < Capacity; j++) begin
                if (res_fire && res_oh[j] && occ_v[i]) age_d[i][j] = 1'b1;
            end
        end
    end

    // Slot state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Capacity; i++) begin
                state_q[i] <= SlotFree;
                id_q[i]    <= '0;
                data_q[i]  <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < Capacity; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                data_q[i]  <= data_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

`ifdef SIMMEM_WRESP_BANK_ASSERT_EN
    logic [10:0] stall_cnt_q, stall_cnt_d;

    // Count consecutive cycles a response waits with no matching reservation
    always_comb begin
        stall_cnt_d = '0;
        if (rsp_valid_i && !rsp_ready_o) begin
            stall_cnt_d = (stall_cnt_q == 11'd1000) ? stall_cnt_q : stall_cnt_q + 11'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    a_released_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(released_addr_onehot_o));
    a_released_is_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (released_addr_onehot_o != '0) |-> (released_addr_onehot_o == out_oh));
    a_released_enabled: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (released_addr_onehot_o & ~release_en_onehot_i) == '0);
    a_rsp_orphan: assert property (@(posedge clk_i) disable iff (!rst_ni)
        stall_cnt_q < 11'd1000)
        else $error("write response without matching reservation for 1000 cycles");
`endif

endmodule

// File: tb/tb_simmem_wresp_bank.sv
// Directed bench for simmem_wresp_bank with hand-computed expectations.
module tb_simmem_wresp_bank;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       res_valid_i;
    logic [3:0] res_id_i;
    logic       res_ready_o;
    logic [2:0] res_iid_o;
    logic       rsp_valid_i;
    logic [3:0] rsp_id_i;
    logic [1:0] rsp_data_i;
    logic       rsp_ready_o;
    logic [7:0] release_en_onehot_i;
    logic [7:0] released_addr_onehot_o;
    logic       out_valid_o;
    logic [3:0] out_id_o;
    logic [1:0] out_data_o;
    logic       out_ready_i;

    int n_chk = 0;
    int n_bad = 0;

    simmem_wresp_bank dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .res_valid_i           (res_valid_i),
        .res_id_i              (res_id_i),
        .res_ready_o           (res_ready_o),
        .res_iid_o             (res_iid_o),
        .rsp_valid_i           (rsp_valid_i),
        .rsp_id_i              (rsp_id_i),
        .rsp_data_i            (rsp_data_i),
        .rsp_ready_o           (rsp_ready_o),
        .release_en_onehot_i   (release_en_onehot_i),
        .released_addr_onehot_o(released_addr_onehot_o),
        .out_valid_o           (out_valid_o),
        .out_id_o              (out_id_o),
        .out_data_o            (out_data_o),
        .out_ready_i           (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        res_valid_i = 0; res_id_i = 0;
        rsp_valid_i = 0; rsp_id_i = 0; rsp_data_i = 0;
        release_en_onehot_i = 0; out_ready_i = 0;
    endtask

    task automatic reserve(input logic [3:0] id, input logic [2:0] exp_iid);
        res_valid_i = 1; res_id_i = id; #1;
        chk("res_iid", res_iid_o, exp_iid);
        tick();
        res_valid_i = 0;
    endtask

    task automatic fill(input logic [3:0] id, input logic [1:0] d);
        rsp_valid_i = 1; rsp_id_i = id; rsp_data_i = d; #1;
        chk("rsp_ready", rsp_ready_o, 1);
        tick();
        rsp_valid_i = 0;
    endtask

    // Release with out_ready high and check the presented response
    task automatic rel(input logic [7:0] en, input logic [3:0] id, input logic [1:0] d,
                       input logic [7:0] oh);
        release_en_onehot_i = en; out_ready_i = 1; #1;
        chk("out_valid", out_valid_o, 1);
        chk("out_id", out_id_o, id);
        chk("out_data", out_data_o, d);
        chk("released", released_addr_onehot_o, oh);
        tick();
        release_en_onehot_i = 0; out_ready_i = 0;
    endtask

    initial begin
        idle();
        rst_ni = 0;
        #2;
        chk("rst res_ready", res_ready_o, 1);
        chk("rst res_iid", res_iid_o, 0);
        chk("rst rsp_ready", rsp_ready_o, 0);
        chk("rst out_valid", out_valid_o, 0);
        chk("rst out_id", out_id_o, 0);
        chk("rst out_data", out_data_o, 0);
        chk("rst released", released_addr_onehot_o, 0);
        tick();
        rst_ni = 1;
        tick();

        // Oldest eligible first across different IDs
        reserve(4'd3, 3'd0);
        reserve(4'd5, 3'd1);
        fill(4'd5, 2'd0);
        fill(4'd3, 2'd2);
        rel(8'b11, 4'd3, 2'd2, 8'h01);
        rel(8'b11, 4'd5, 2'd0, 8'h02);
        #1 chk("t1 empty", out_valid_o, 0);

        // Same-ID ordering blocks the younger slot
        reserve(4'd2, 3'd0);
        reserve(4'd2, 3'd1);
        fill(4'd2, 2'd1);
        fill(4'd2, 2'd3);
        release_en_onehot_i = 8'b10; #1;
        chk("t2 blocked", out_valid_o, 0);
        chk("t2 blocked rel", released_addr_onehot_o, 0);
        rel(8'b11, 4'd2, 2'd1, 8'h01);
        rel(8'b11, 4'd2, 2'd3, 8'h02);

        // Full bank
        for (int i = 0; i < 8; i++) begin
            reserve(4'(i), 3'(i));
            fill(4'(i), 2'(i));
        end
        chk("t3 full", res_ready_o, 0);
        rel(8'h10, 4'd4, 2'd0, 8'h10);
        chk("t3 ready", res_ready_o, 1);
        chk("t3 iid", res_iid_o, 4);
        for (int i = 0; i < 8; i++) begin
            if (i != 4) rel(8'hFF, 4'(i), 2'(i), 8'(1 << i));
        end
        chk("t3 drained", out_valid_o, 0);

        // Simultaneous reserve / fill / release
        reserve(4'd1, 3'd0);
        reserve(4'd2, 3'd1);
        fill(4'd1, 2'd0);
        res_valid_i = 1; res_id_i = 4'd6;
        rsp_valid_i = 1; rsp_id_i = 4'd2; rsp_data_i = 2'd1;
        release_en_onehot_i = 8'h01; out_ready_i = 1; #1;
        chk("t4 iid", res_iid_o, 2);
        chk("t4 rsp_ready", rsp_ready_o, 1);
        chk("t4 released", released_addr_onehot_o, 8'h01);
        tick();
        idle(); #1;
        chk("t4 slot0 free", res_iid_o, 0);
        rsp_id_i = 4'd6; #1;
        chk("t4 slot2 reserved", rsp_ready_o, 1);
        release_en_onehot_i = 8'h02; #1;
        chk("t4 slot1 filled", out_valid_o, 1);
        chk("t4 slot1 id", out_id_o, 2);
        release_en_onehot_i = 0;
        fill(4'd6, 2'd3);
        rel(8'hFF, 4'd2, 2'd1, 8'h02);
        rel(8'hFF, 4'd6, 2'd3, 8'h04);

        // Unmatched response stalls until reservation
        rsp_valid_i = 1; rsp_id_i = 4'd7; rsp_data_i = 2'd1; #1;
        chk("t5 stall", rsp_ready_o, 0);
        tick();
        chk("t5 stall2", rsp_ready_o, 0);
        res_valid_i = 1; res_id_i = 4'd7;
        tick();
        res_valid_i = 0; #1;
        chk("t5 match", rsp_ready_o, 1);
        tick();
        rsp_valid_i = 0;
        rel(8'hFF, 4'd7, 2'd1, 8'h01);

        // Reset with three filled slots
        for (int i = 1; i < 4; i++) begin
            reserve(4'(i), 3'(i - 1));
            fill(4'(i), 2'(i));
        end
        release_en_onehot_i = 8'hFF; #1;
        chk("t6 pre", out_valid_o, 1);
        rst_ni = 0; #1;
        chk("t6 out_valid", out_valid_o, 0);
        chk("t6 res_ready", res_ready_o, 1);
        chk("t6 res_iid", res_iid_o, 0);
        chk("t6 released", released_addr_onehot_o, 0);
        tick();
        rst_ni = 1;
        tick();
        chk("t6 post", out_valid_o, 0);
        idle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
